// File: rtl/demux_oht_stream.sv
// rtl/demux_oht_stream.sv - one-hot select stream demux with per-packet route lock
// Optional output register stage enabled by defining DEMUX_OHT_STREAM_REG_EN.
module demux_oht_stream #(
    parameter type DAT_T = logic [8-1:0],
    parameter int  WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sel,
    input  logic             s_vld,
    output logic             s_rdy,
    input  DAT_T             s_dat,
    input  logic             s_lst,
    output logic [WIDTH-1:0] m_vld,
    input  logic [WIDTH-1:0] m_rdy,
    output DAT_T             m_dat,
    output logic             m_lst,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] route_q, route_d;

    logic             sel_onehot;
    logic             fwd_mode;
    logic [WIDTH-1:0] cur_route;
    logic             s_xfer;

    // In IDLE the packet head picks its route straight from sel; afterwards it is locked.
    always_comb begin
        sel_onehot = (sel != '0) && ((sel & (sel - WIDTH'(1))) == '0);
        cur_route  = (state_q == IDLE) ? sel : route_q;
        fwd_mode   = (state_q == PASS) || ((state_q == IDLE) && sel_onehot);
        s_xfer     = s_vld && s_rdy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            route_q <= '0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
        end
    end

    always_comb begin
        state_d = state_q;
        route_d = route_q;
        if (s_xfer) begin
            case (state_q)
                IDLE:    state_d = s_lst ? IDLE : (sel_onehot ? PASS : DROP);
                PASS:    state_d = s_lst ? IDLE : PASS;
                DROP:    state_d = s_lst ? IDLE : DROP;
                default: state_d = IDLE;
            endcase
            if (fwd_mode) begin
                route_d = cur_route;
            end
        end
    end

`ifdef DEMUX_OHT_STREAM_REG_EN
    logic             buf_vld_q, buf_vld_d;
    logic [WIDTH-1:0] buf_dst_q, buf_dst_d;
    DAT_T             buf_dat_q, buf_dat_d;
    logic             buf_lst_q, buf_lst_d;
    logic             out_take;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_vld_q <= 1'b0;
            buf_dst_q <= '0;
            buf_dat_q <= '0;
            buf_lst_q <= 1'b0;
        end else begin
            buf_vld_q <= buf_vld_d;
            buf_dst_q <= buf_dst_d;
            buf_dat_q <= buf_dat_d;
            buf_lst_q <= buf_lst_d;
        end
    end

    // A new load may replace a beat being taken in the same cycle, keeping full throughput.
    always_comb begin
        out_take  = buf_vld_q && ((buf_dst_q & m_rdy) != '0);
        buf_vld_d = buf_vld_q;
        buf_dst_d = buf_dst_q;
        buf_dat_d = buf_dat_q;
        buf_lst_d = buf_lst_q;
        if (s_xfer && fwd_mode) begin
            buf_vld_d = 1'b1;
            buf_dst_d = cur_route;
            buf_dat_d = s_dat;
            buf_lst_d = s_lst;
        end else if (out_take) begin
            buf_vld_d = 1'b0;
        end
    end

    always_comb begin
        s_rdy = 1'b0;
        m_vld = '0;
        m_dat = '0;
        m_lst = 1'b0;
        err   = 1'b0;
        if (!rst) begin
            s_rdy = fwd_mode ? (!buf_vld_q || out_take) : 1'b1;
            m_vld = buf_vld_q ? buf_dst_q : '0;
            m_dat = buf_dat_q;
            m_lst = buf_lst_q;
            err   = s_vld && (state_q == IDLE) && !sel_onehot;
        end
    end
`else
    always_comb begin
        s_rdy = 1'b0;
        m_vld = '0;
        m_dat = '0;
        m_lst = 1'b0;
        err   = 1'b0;
        if (!rst) begin
            s_rdy = fwd_mode ? ((cur_route & m_rdy) != '0) : 1'b1;
            m_vld = fwd_mode ? ({WIDTH{s_vld}} & cur_route) : '0;
            m_dat = s_dat;
            m_lst = s_lst;
            err   = s_vld && (state_q == IDLE) && !sel_onehot;
        end
    end
`endif

endmodule

// File: tb/tb_demux_oht_stream.sv
// tb/tb_demux_oht_stream.sv - directed bench with packet-level reference model for demux_oht_stream
module tb_demux_oht_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sel;
    logic       s_vld;
    logic       s_rdy;
    logic [7:0] s_dat;
    logic       s_lst;
    logic [3:0] m_vld;
    logic [3:0] m_rdy;
    logic [7:0] m_dat;
    logic       m_lst;
    logic       err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    demux_oht_stream dut (
        .clk   (clk),
        .rst   (rst),
        .sel   (sel),
        .s_vld (s_vld),
        .s_rdy (s_rdy),
        .s_dat (s_dat),
        .s_lst (s_lst),
        .m_vld (m_vld),
        .m_rdy (m_rdy),
        .m_dat (m_dat),
        .m_lst (m_lst),
        .err   (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Packet-level model: is a packet open, is it being dropped, which port is it locked to.
    bit         in_pkt   = 1'b0;
    bit         dropping = 1'b0;
    int         lock_idx = 0;

    initial begin
        bit         legal;
        int         idx_now;
        logic       e_rdy, e_err, e_lst;
        logic [3:0] e_vld;
        logic [7:0] e_dat;
        forever begin
            @(negedge clk);
            legal   = 1'b0;
            idx_now = lock_idx;
            e_err   = 1'b0;
            if (rst) begin
                e_rdy = 1'b0;
                e_vld = 4'b0;
                e_dat = 8'h00;
                e_lst = 1'b0;
            end else begin
                e_dat = s_dat;
                e_lst = s_lst;
                if (!in_pkt) begin
                    legal = ($countones(sel) == 1);
                    if (legal) begin
                        idx_now = onehot_idx(sel);
                        e_rdy   = m_rdy[idx_now];
                        e_vld   = s_vld ? sel : 4'b0;
                    end else begin
                        e_rdy = 1'b1;
                        e_vld = 4'b0;
                        e_err = s_vld;
                    end
                end else if (dropping) begin
                    e_rdy = 1'b1;
                    e_vld = 4'b0;
                end else begin
                    e_rdy = m_rdy[lock_idx];
                    e_vld = s_vld ? (4'b0001 << lock_idx) : 4'b0;
                end
            end
            chk("model_s_rdy", 32'(s_rdy), 32'(e_rdy));
            chk("model_m_vld", 32'(m_vld), 32'(e_vld));
            chk("model_err",   32'(err),   32'(e_err));
            if (e_vld != 4'b0 || rst) begin
                chk("model_m_dat", 32'(m_dat), 32'(e_dat));
                chk("model_m_lst", 32'(m_lst), 32'(e_lst));
            end
            @(posedge clk);
            if (rst) begin
                in_pkt   = 1'b0;
                dropping = 1'b0;
            end else if (s_vld && e_rdy) begin
                if (!in_pkt) begin
                    dropping = !legal;
                    lock_idx = idx_now;
                end
                in_pkt = !s_lst;
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge, return at the falling edge.
    task automatic step(input logic r, input logic v, input logic [3:0] sl,
                        input logic [7:0] d, input logic l, input logic [3:0] mr);
        @(posedge clk);
        #1;
        rst   = r;
        s_vld = v;
        sel   = sl;
        s_dat = d;
        s_lst = l;
        m_rdy = mr;
        @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        s_vld = 1'b1;
        sel   = 4'b0100;
        s_dat = 8'h11;
        s_lst = 1'b0;
        m_rdy = 4'hF;

        // reset held two cycles with a valid beat present
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 4'b0100, 8'h11, 0, 4'hF);
            chk("rst_m_vld", 32'(m_vld), 32'h0);
            chk("rst_err",   32'(err),   32'h0);
            chk("rst_s_rdy", 32'(s_rdy), 32'h0);
            chk("rst_m_dat", 32'(m_dat), 32'h0);
        end
        step(0, 0, 4'b0000, 8'h00, 0, 4'hF);
        chk("idle_m_vld", 32'(m_vld), 32'h0);

        // 3-beat packet to port 2, sel changes mid-packet
        step(0, 1, 4'b0100, 8'hA1, 0, 4'hF);
        chk("p2_b1_vld", 32'(m_vld), 32'h4);
        chk("p2_b1_dat", 32'(m_dat), 32'hA1);
        step(0, 1, 4'b0001, 8'hA2, 0, 4'hF);
        chk("p2_b2_vld", 32'(m_vld), 32'h4);
        chk("p2_b2_dat", 32'(m_dat), 32'hA2);
        step(0, 1, 4'b0001, 8'hA3, 1, 4'hF);
        chk("p2_b3_vld", 32'(m_vld), 32'h4);
        chk("p2_b3_lst", 32'(m_lst), 32'h1);
        step(0, 0, 4'b0001, 8'h00, 0, 4'hF);

        // multi-hot select drops the packet, next packet routed to port 0
        step(0, 1, 4'b0110, 8'h55, 0, 4'h0);
        chk("drop_b1_err", 32'(err),   32'h1);
        chk("drop_b1_rdy", 32'(s_rdy), 32'h1);
        chk("drop_b1_vld", 32'(m_vld), 32'h0);
        step(0, 1, 4'b0110, 8'h56, 1, 4'h0);
        chk("drop_b2_err", 32'(err),   32'h0);
        chk("drop_b2_rdy", 32'(s_rdy), 32'h1);
        chk("drop_b2_vld", 32'(m_vld), 32'h0);
        step(0, 1, 4'b0001, 8'h57, 1, 4'hF);
        chk("after_drop_vld", 32'(m_vld), 32'h1);
        step(0, 1, 4'b0000, 8'h58, 1, 4'hF);
        chk("zero_sel_err", 32'(err), 32'h1);

        // backpressure on port 1; ready on port 0 must not unblock
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 4'b0010, 8'h77, 1, 4'b0001);
            chk("bp_s_rdy", 32'(s_rdy), 32'h0);
            chk("bp_m_vld", 32'(m_vld), 32'h2);
            chk("bp_m_dat", 32'(m_dat), 32'h77);
        end
        step(0, 1, 4'b0010, 8'h77, 1, 4'hF);
        chk("bp_release_rdy", 32'(s_rdy), 32'h1);

        // back-to-back single-beat packets
        step(0, 1, 4'b0001, 8'hB0, 1, 4'hF);
        chk("b2b_0", 32'(m_vld), 32'h1);
        step(0, 1, 4'b1000, 8'hB1, 1, 4'hF);
        chk("b2b_1", 32'(m_vld), 32'h8);
        step(0, 1, 4'b0001, 8'hB2, 1, 4'hF);
        chk("b2b_2", 32'(m_vld), 32'h1);

        // reset during beat 2 of a 4-beat packet; tail becomes a new packet
        step(0, 1, 4'b0100, 8'hC1, 0, 4'hF);
        chk("rmid_b1_vld", 32'(m_vld), 32'h4);
        step(1, 1, 4'b0100, 8'hC2, 0, 4'hF);
        chk("rmid_rst_vld", 32'(m_vld), 32'h0);
        chk("rmid_rst_rdy", 32'(s_rdy), 32'h0);
        step(0, 1, 4'b1000, 8'hC3, 0, 4'hF);
        chk("rmid_b3_vld", 32'(m_vld), 32'h8);
        chk("rmid_b3_dat", 32'(m_dat), 32'hC3);
        step(0, 1, 4'b0001, 8'hC4, 1, 4'hF);
        chk("rmid_b4_vld", 32'(m_vld), 32'h8);
        step(0, 0, 4'b0000, 8'h00, 0, 4'hF);
        chk("end_idle_vld", 32'(m_vld), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
